hamming_tx_ctrl: RTL and testbench

Serial-in / serial-out sequencer for the 11→15 Hamming transmit path. It collects 11 data bits from the `shift`/`sl_in` serial input and encodes them into a 15-bit codeword. It then streams the codeword out one bit per accepted handshake. It sits between the serial input stage and the downstream serial link, and owns all bit counting and frame sequencing.

---
 rtl/hamming_tx_ctrl_if.sv | 28 ++
 rtl/hamming_tx_ctrl.sv | 119 +++++++++++
 tb/tb_hamming_tx_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hamming_tx_ctrl_if.sv
// hamming_tx_ctrl_if: serial-in, codeword and serial-out signals of hamming_tx_ctrl.
// The codeword is 16 bits when HAM_SECDED_EN is defined and 15 bits otherwise.
interface hamming_tx_ctrl_if;
`ifdef HAM_SECDED_EN
  localparam int W = 16;
`else
  localparam int W = 15;
`endif
  logic          shift;
  logic          sl_in;
  logic [10:0]   datall;
  logic          countfull;
  logic [W-1:0]  hammingout;
  logic          so_valid;
  logic          so_ready;
  logic          so_data;
  logic          so_last;
  logic          busy;
  logic          overrun;
  modport master (
    input  shift, sl_in, so_ready,
    output datall, countfull, hammingout, so_valid, so_data, so_last, busy, overrun
  );
  modport slave (
    output shift, sl_in, so_ready,
    input  datall, countfull, hammingout, so_valid, so_data, so_last, busy, overrun
  );
endinterface

// File: rtl/hamming_tx_ctrl.sv
// hamming_tx_ctrl: collects 11 serial bits, encodes an 11->15 Hamming codeword and streams it out.
// Defining HAM_SECDED_EN adds an overall parity bit (16-bit codeword and frame).
module hamming_tx_ctrl (
  input  logic             clk,
  input  logic             RST,
  hamming_tx_ctrl_if.master bus
);
`ifdef HAM_SECDED_EN
  localparam int W = 16;
`else
  localparam int W = 15;
`endif
  typedef enum logic [1:0] {IDLE, COLLECT, ENCODE, SEND} state_t;
  state_t       state, state_n;
  logic [3:0]   cnt, cnt_n, idx, idx_n;
  logic [10:0]  datall, datall_n;
  logic [W-1:0] code, code_n;
  logic         countfull, countfull_n, valid, valid_n, sdata, sdata_n;
  logic         last, last_n, busy, busy_n, overrun, overrun_n;
  // Data d0..d10 sit at positions 3,5,6,7,9..15; code bit i-1 holds position i.
  function automatic logic [W-1:0] encode(input logic [10:0] d);
    logic [14:0] c;
    c = {d[10:4], ^d[10:4], d[3:1], ^{d[10:7], d[3:1]}, d[0],
         ^{d[10:9], d[6:5], d[3:2], d[0]},
         ^{d[10], d[8], d[6], d[4], d[3], d[1], d[0]}};
`ifdef HAM_SECDED_EN
    return {^c, c};
`else
    return c;
`endif
  endfunction
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      datall    <= '0;
      code      <= '0;
      countfull <= 1'b0;
      valid     <= 1'b0;
      sdata     <= 1'b0;
      last      <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      datall    <= datall_n;
      code      <= code_n;
      countfull <= countfull_n;
      valid     <= valid_n;
      sdata     <= sdata_n;
      last      <= last_n;
      busy      <= busy_n;
      overrun   <= overrun_n;
    end
  end
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    idx_n       = idx;
    datall_n    = datall;
    code_n      = code;
    countfull_n = 1'b0;
    valid_n     = valid;
    sdata_n     = sdata;
    last_n      = last;
    busy_n      = busy;
    overrun_n   = overrun | (bus.shift & (state == ENCODE || state == SEND));
    case (state)
      IDLE, COLLECT: begin
        if (bus.shift) begin
          datall_n = {datall[9:0], bus.sl_in};
          cnt_n    = cnt + 4'd1;
          state_n  = COLLECT;
          if (cnt == 4'd10) begin
            cnt_n       = '0;
            state_n     = ENCODE;
            countfull_n = 1'b1;
            busy_n      = 1'b1;
          end
        end
      end
      ENCODE: begin
        code_n  = encode(datall);
        state_n = SEND;
        valid_n = 1'b1;
        sdata_n = code_n[0];
        idx_n   = '0;
        last_n  = 1'b0;
      end
      default: begin
        if (bus.so_ready) begin
          if (last) begin
            state_n = IDLE;
            valid_n = 1'b0;
            sdata_n = 1'b0;
            last_n  = 1'b0;
            busy_n  = 1'b0;
            idx_n   = '0;
          end else begin
            idx_n   = idx + 4'd1;
            sdata_n = code[idx_n];
            last_n  = idx_n == 4'(W - 1);
          end
        end
      end
    endcase
  end
  assign bus.datall     = datall;
  assign bus.countfull  = countfull;
  assign bus.hammingout = code;
  assign bus.so_valid   = valid;
  assign bus.so_data    = sdata;
  assign bus.so_last    = last;
  assign bus.busy       = busy;
  assign bus.overrun    = overrun;
endmodule

// File: tb/tb_hamming_tx_ctrl.sv
// tb_hamming_tx_ctrl: randomized self-checking bench for hamming_tx_ctrl against a position-rule Hamming model.
module tb_hamming_tx_ctrl;
`ifdef HAM_SECDED_EN
  localparam int W = 16;
  localparam bit SEC = 1'b1;
`else
  localparam int W = 15;
  localparam bit SEC = 1'b0;
`endif
  logic clk = 1'b0;
  logic RST = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  bit ovr_exp = 1'b0;
  hamming_tx_ctrl_if bus();
  hamming_tx_ctrl dut (.clk(clk), .RST(RST), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [15:0] ref_code(input logic [10:0] d);
    logic [15:0] c;
    int k;
    bit par;
    c = '0;
    k = 0;
    for (int p = 1; p <= 15; p++)
      if ((p & (p - 1)) != 0) begin
        c[p-1] = d[k];
        k++;
      end
    for (int p = 1; p <= 8; p = p * 2) begin
      par = 1'b0;
      for (int q = 1; q <= 15; q++)
        if ((q & p) != 0 && q != p) par = par ^ c[q-1];
      c[p-1] = par;
    end
    if (SEC) c[15] = ^c[14:0];
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [10:0] d, input bit gaps);
    for (int i = 10; i >= 0; i--) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      bus.shift = 1'b1;
      bus.sl_in = d[i];
      tick();
      bus.shift = 1'b0;
      bus.sl_in = 1'b0;
    end
  endtask

  task automatic frame_start(input logic [10:0] d);
    logic [15:0] e;
    e = ref_code(d);
    n_checks++;
    if (bus.countfull !== 1'b1 || bus.busy !== 1'b1 || bus.datall !== d || bus.so_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL capture: countfull=%b busy=%b datall=%h valid=%b, required 1 1 %h 0",
               bus.countfull, bus.busy, bus.datall, bus.so_valid, d);
    end
    tick();
    n_checks++;
    if (bus.hammingout !== e[W-1:0] || bus.so_valid !== 1'b1 || bus.countfull !== 1'b0 ||
        bus.so_data !== e[0] || bus.overrun !== ovr_exp) begin
      n_fail++;
      $display("FAIL encode: code=%h valid=%b countfull=%b data=%b ovr=%b, required %h 1 0 %b %b",
               bus.hammingout, bus.so_valid, bus.countfull, bus.so_data, bus.overrun, e[W-1:0], e[0], ovr_exp);
    end
  endtask

  task automatic drain(input logic [10:0] d, input bit rnd, input int stall_at, input int shift_at);
    logic [15:0] e;
    int idx, cyc, stalls;
    bit done, shifted, rdy;
    e = ref_code(d);
    idx = 0; cyc = 0; stalls = 0; done = 1'b0; shifted = 1'b0;
    while (!done && cyc < 200) begin
      n_checks++;
      if (bus.so_valid !== 1'b1 || bus.so_data !== e[idx] || bus.so_last !== (idx == W - 1) ||
          bus.busy !== 1'b1 || bus.overrun !== ovr_exp) begin
        n_fail++;
        $display("FAIL stream bit %0d: valid=%b data=%b last=%b busy=%b ovr=%b, required 1 %b %b 1 %b",
                 idx, bus.so_valid, bus.so_data, bus.so_last, bus.busy, bus.overrun,
                 e[idx], idx == W - 1, ovr_exp);
      end
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (idx == stall_at && stalls < 3) begin
        rdy = 1'b0;
        stalls++;
      end
      if (idx == shift_at && !shifted) begin
        bus.shift = 1'b1;
        bus.sl_in = 1'($urandom_range(0, 1));
        shifted = 1'b1;
        ovr_exp = 1'b1;
      end
      bus.so_ready = rdy;
      tick();
      bus.shift = 1'b0;
      bus.so_ready = 1'b0;
      if (rdy) begin
        if (idx == W - 1) done = 1'b1;
        else idx++;
      end
      cyc++;
    end
    n_checks++;
    if (!done || bus.so_valid !== 1'b0 || bus.so_last !== 1'b0 || bus.so_data !== 1'b0 ||
        bus.busy !== 1'b0 || bus.datall !== d) begin
      n_fail++;
      $display("FAIL frame end: done=%b valid=%b last=%b data=%b busy=%b datall=%h, required 1 0 0 0 0 %h",
               done, bus.so_valid, bus.so_last, bus.so_data, bus.busy, bus.datall, d);
    end
  endtask

  task automatic test_reset();
    bus.shift = 1'b0; bus.sl_in = 1'b0; bus.so_ready = 1'b0;
    RST = 1'b0;
    tick(); tick();
    n_checks++;
    if ({bus.datall, bus.hammingout, bus.countfull, bus.so_valid, bus.so_data, bus.so_last, bus.busy, bus.overrun} !== '0) begin
      n_fail++;
      $display("FAIL reset: datall=%h code=%h cf=%b v=%b d=%b l=%b busy=%b ovr=%b, required all 0",
               bus.datall, bus.hammingout, bus.countfull, bus.so_valid, bus.so_data, bus.so_last, bus.busy, bus.overrun);
    end
    #4 RST = 1'b1;
    for (int i = 4; i >= 0; i--) begin
      bus.shift = 1'b1;
      bus.sl_in = (i != 3);
      tick();
    end
    bus.shift = 1'b0;
    n_checks++;
    if (bus.datall !== 11'h017 || bus.countfull !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL partial: datall=%h cf=%b busy=%b, required 017 0 0", bus.datall, bus.countfull, bus.busy);
    end
    #1 RST = 1'b0;
    #1;
    n_checks++;
    if (bus.datall !== 11'h000 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL async reset collect: datall=%h busy=%b, required 000 0", bus.datall, bus.busy);
    end
    #3 RST = 1'b1;
    feed(11'h001, 1'b0);
    frame_start(11'h001);
    n_checks++;
    if (bus.hammingout !== (SEC ? 16'h8007 : 16'h0007)) begin
      n_fail++;
      $display("FAIL vec001: code=%h, required %h", bus.hammingout, SEC ? 16'h8007 : 16'h0007);
    end
    drain(11'h001, 1'b0, -1, -1);
  endtask

  task automatic test_vectors();
    feed(11'h400, 1'b0);
    frame_start(11'h400);
    drain(11'h400, 1'b0, -1, -1);
    n_checks++;
    if (bus.hammingout !== (SEC ? 16'hC08B : 16'h408B)) begin
      n_fail++;
      $display("FAIL vec400: code=%h, required %h", bus.hammingout, SEC ? 16'hC08B : 16'h408B);
    end
  endtask

  task automatic test_stall();
    feed(11'h7FF, 1'b1);
    frame_start(11'h7FF);
    drain(11'h7FF, 1'b0, 5, -1);
    n_checks++;
    if (bus.hammingout !== (SEC ? 16'hFFFF : 16'h7FFF)) begin
      n_fail++;
      $display("FAIL vec7ff: code=%h, required %h", bus.hammingout, SEC ? 16'hFFFF : 16'h7FFF);
    end
  endtask

  task automatic test_overrun();
    logic [10:0] d;
    for (int f = 0; f < 2; f++) begin
      d = 11'($urandom);
      feed(d, 1'b1);
      frame_start(d);
      drain(d, 1'b1, -1, f == 0 ? 7 : -1);
    end
  endtask

  task automatic test_zero();
    feed(11'h000, 1'b0);
    frame_start(11'h000);
    drain(11'h000, 1'b0, -1, -1);
    n_checks++;
    if (bus.hammingout !== '0) begin
      n_fail++;
      $display("FAIL vec000: code=%h, required 0", bus.hammingout);
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] d;
    for (int f = 0; f < 6; f++) begin
      d = 11'($urandom);
      feed(d, f[0]);
      frame_start(d);
      drain(d, f != 0, -1, -1);
    end
  endtask

  task automatic test_reset_send();
    logic [10:0] d;
    d = 11'h5A5;
    feed(d, 1'b0);
    frame_start(d);
    bus.so_ready = 1'b1;
    repeat (4) tick();
    bus.so_ready = 1'b0;
    #1 RST = 1'b0;
    #1;
    ovr_exp = 1'b0;
    n_checks++;
    if ({bus.datall, bus.hammingout, bus.countfull, bus.so_valid, bus.so_data, bus.so_last, bus.busy, bus.overrun} !== '0) begin
      n_fail++;
      $display("FAIL async reset send: datall=%h code=%h cf=%b v=%b d=%b l=%b busy=%b ovr=%b, required all 0",
               bus.datall, bus.hammingout, bus.countfull, bus.so_valid, bus.so_data, bus.so_last, bus.busy, bus.overrun);
    end
    #3 RST = 1'b1;
    d = 11'($urandom);
    feed(d, 1'b1);
    frame_start(d);
    drain(d, 1'b1, -1, -1);
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_stall();
    test_overrun();
    test_zero();
    test_back_to_back();
    test_reset_send();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
